// File: rtl/paralelo_serial_tx_if.sv
// Handshake and serial-line bundle for the 10-bit serial transmitter.
//
// Signals:
//   entradas      parallel word offered to the transmitter
//   valido        entradas holds a word to send
//   listo         transmitter takes entradas at the next rising edge if valido=1
//   salida        serial bit, MSB first
//   inicioPalabra high while salida carries the MSB of a word
//   palabraDatos  high for all bits of a data word, low during commas
//
// Modports:
//   master  word source (drives entradas/valido, observes the line)
//   slave   transmitter (paralelo_serial_tx)
interface paralelo_serial_tx_if #(
    parameter int unsigned ANCHO = 10
);
    logic [ANCHO-1:0] entradas;
    logic             valido;
    logic             listo;
    logic             salida;
    logic             inicioPalabra;
    logic             palabraDatos;

    modport master (
        output entradas,
        output valido,
        input  listo,
        input  salida,
        input  inicioPalabra,
        input  palabraDatos
    );

    modport slave (
        input  entradas,
        input  valido,
        output listo,
        output salida,
        output inicioPalabra,
        output palabraDatos
    );
endinterface

// File: rtl/paralelo_serial_tx.sv
// Parallel-to-serial transmitter for the 10-bit serial link.
// After reset it sends N_SYNC comma words so the receiver can align, then
// serialises words accepted over a valid/ready handshake, inserting a comma at
// every word boundary where no word is offered.
//
// Ports:
//   clk          system clock, one serial bit per rising edge
//   rstContador  synchronous, active-high reset
//   bus          paralelo_serial_tx_if.slave (entradas, valido, listo, salida,
//                inicioPalabra, palabraDatos)
//
// Build option:
//   COMMA_RD_EN  when defined, commas alternate COMMA / ~COMMA (running
//                disparity), starting with COMMA after reset; data words do
//                not affect the alternation.
module paralelo_serial_tx #(
    parameter int unsigned        ANCHO  = 10,
    parameter logic [ANCHO-1:0]   COMMA  = 10'b0011111010,
    parameter int unsigned        N_SYNC = 3
) (
    input  logic                  clk,
    input  logic                  rstContador,
    paralelo_serial_tx_if.slave   bus
);

    localparam int unsigned CW = (ANCHO > 1) ? $clog2(ANCHO) : 1;
    localparam int unsigned SW = (N_SYNC > 1) ? $clog2(N_SYNC + 1) : 1;

    typedef enum logic [0:0] {
        StSinc,
        StActivo
    } estado_e;

    estado_e          r_estado, w_estado_d;
    logic [CW-1:0]    r_contador, w_contador_d;
    logic [SW-1:0]    r_cuentaSync, w_cuentaSync_d;
    logic [ANCHO-1:0] r_shift, w_shift_d;
    logic             r_salida, w_salida_d;
    logic             r_inicio, w_inicio_d;
    logic             r_datos, w_datos_d;
    logic             r_rd, w_rd_d;

    logic             w_frontera;
    logic             w_listo;
    logic             w_acepta;
    logic [ANCHO-1:0] w_comma;
    logic [ANCHO-1:0] w_palabra;

    assign w_frontera = (r_contador == CW'(ANCHO - 1));
    assign w_listo    = (r_estado == StActivo) && w_frontera;
    assign w_acepta   = w_listo && bus.valido;

`ifdef COMMA_RD_EN
    assign w_comma = r_rd ? ~COMMA : COMMA;
`else
    assign w_comma = COMMA;
`endif

    assign w_palabra = w_acepta ? bus.entradas : w_comma;

    always_comb begin
        w_estado_d     = r_estado;
        w_contador_d   = r_contador;
        w_cuentaSync_d = r_cuentaSync;
        w_shift_d      = r_shift;
        w_salida_d     = r_salida;
        w_inicio_d     = 1'b0;
        w_datos_d      = r_datos;
        w_rd_d         = r_rd;

        if (w_frontera) begin
            w_contador_d = '0;
            w_shift_d    = w_palabra;
            w_salida_d   = w_palabra[ANCHO-1];
            w_inicio_d   = 1'b1;
            w_datos_d    = w_acepta;
            // Disparity only advances on commas; data leaves it untouched.
            if (!w_acepta) begin
                w_rd_d = ~r_rd;
            end
            if (r_estado == StSinc) begin
                w_cuentaSync_d = r_cuentaSync + SW'(1);
                // This boundary loads comma number N_SYNC.
                if (r_cuentaSync == SW'(N_SYNC - 1)) begin
                    w_estado_d = StActivo;
                end
            end
        end else begin
            w_contador_d = r_contador + CW'(1);
            // Shift register is left-aligned: bit ANCHO-2 is the next bit out.
            w_shift_d    = r_shift << 1;
            w_salida_d   = r_shift[ANCHO-2];
        end
    end

    always_ff @(posedge clk) begin
        if (rstContador) begin
            r_estado     <= StSinc;
            r_contador   <= CW'(ANCHO - 1);
            r_cuentaSync <= '0;
            r_shift      <= COMMA;
            r_salida     <= 1'b0;
            r_inicio     <= 1'b0;
            r_datos      <= 1'b0;
            r_rd         <= 1'b0;
        end else begin
            r_estado     <= w_estado_d;
            r_contador   <= w_contador_d;
            r_cuentaSync <= w_cuentaSync_d;
            r_shift      <= w_shift_d;
            r_salida     <= w_salida_d;
            r_inicio     <= w_inicio_d;
            r_datos      <= w_datos_d;
            r_rd         <= w_rd_d;
        end
    end

    assign bus.listo         = w_listo;
    assign bus.salida        = r_salida;
    assign bus.inicioPalabra = r_inicio;
    assign bus.palabraDatos  = r_datos;

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Directed bench for paralelo_serial_tx: sync commas after reset, first data
// word, back-to-back data, idle comma insertion and reset in mid-word.
module tb_paralelo_serial_tx;

    localparam logic [9:0] C_COMMA = 10'b0011111010;

    logic clk;
    logic rstContador;
    int   n_checks;
    int   n_err;
    int   cyc;
    logic tb_rd;

    paralelo_serial_tx_if #(.ANCHO(10)) bus ();

    paralelo_serial_tx #(
        .ANCHO  (10),
        .COMMA  (C_COMMA),
        .N_SYNC (3)
    ) dut (
        .clk         (clk),
        .rstContador (rstContador),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Next expected comma; alternates only when the disparity option is built.
    function automatic logic [9:0] cw();
        logic [9:0] c;
`ifdef COMMA_RD_EN
        c = tb_rd ? ~C_COMMA : C_COMMA;
        tb_rd = ~tb_rd;
`else
        c = C_COMMA;
`endif
        return c;
    endfunction

    // Ten bit cycles of word w; inputs nv/ne are applied right after the
    // boundary edge so they are in place for the next boundary.
    task automatic word(input logic [9:0] w, input logic d, input logic l,
                        input logic nv, input logic [9:0] ne);
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k == 0) begin
                bus.valido   = nv;
                bus.entradas = ne;
            end
            chk("salida", {31'b0, bus.salida}, {31'b0, w[9-k]});
            chk("inicioPalabra", {31'b0, bus.inicioPalabra}, {31'b0, (k == 0)});
            chk("palabraDatos", {31'b0, bus.palabraDatos}, {31'b0, d});
            chk("listo", {31'b0, bus.listo}, {31'b0, (l && k == 9)});
        end
    endtask

    initial begin
        logic [9:0] w_d;
        n_checks     = 0;
        n_err        = 0;
        cyc          = 0;
        tb_rd        = 1'b0;
        rstContador  = 1'b1;
        bus.valido   = 1'b0;
        bus.entradas = 10'h000;

        // Reset held for 4 cycles.
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_salida", {31'b0, bus.salida}, 32'd0);
            chk("rst_listo", {31'b0, bus.listo}, 32'd0);
            chk("rst_inicio", {31'b0, bus.inicioPalabra}, 32'd0);
            chk("rst_datos", {31'b0, bus.palabraDatos}, 32'd0);
        end
        rstContador = 1'b0;
        cyc = 0;

        // Sync commas; valido raised early during comma 3 must be ignored.
        word(cw(), 1'b0, 1'b0, 1'b0, 10'h000);
        word(cw(), 1'b0, 1'b0, 1'b1, 10'b1001101010);
        word(cw(), 1'b0, 1'b1, 1'b1, 10'b1001101010);

        // First data word, then two back-to-back words.
        word(10'b1001101010, 1'b1, 1'b1, 1'b1, 10'b1100110011);
        word(10'b1100110011, 1'b1, 1'b1, 1'b1, 10'b0101010101);
        // valido dropped for exactly one boundary.
        word(10'b0101010101, 1'b1, 1'b1, 1'b0, 10'h000);
        word(cw(), 1'b0, 1'b1, 1'b1, 10'b1110001101);
        // Second idle comma pair to exercise the disparity alternation.
        word(10'b1110001101, 1'b1, 1'b1, 1'b0, 10'h000);
        word(cw(), 1'b0, 1'b1, 1'b0, 10'h000);
        word(cw(), 1'b0, 1'b1, 1'b1, 10'b1011000111);

        // Data word interrupted by reset during its bit-5 cycle.
        w_d = 10'b1011000111;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 0) begin
                bus.entradas = 10'b0110100110;
            end
            chk("mid_salida", {31'b0, bus.salida}, {31'b0, w_d[9-k]});
            chk("mid_datos", {31'b0, bus.palabraDatos}, 32'd1);
        end
        rstContador = 1'b1;
        tick();
        chk("mrst_salida", {31'b0, bus.salida}, 32'd0);
        chk("mrst_listo", {31'b0, bus.listo}, 32'd0);
        chk("mrst_inicio", {31'b0, bus.inicioPalabra}, 32'd0);
        chk("mrst_datos", {31'b0, bus.palabraDatos}, 32'd0);
        rstContador = 1'b0;
        tb_rd = 1'b0;

        // Full sync restarts even though valido stays high throughout.
        word(cw(), 1'b0, 1'b0, 1'b1, 10'b0110100110);
        word(cw(), 1'b0, 1'b0, 1'b1, 10'b0110100110);
        word(cw(), 1'b0, 1'b1, 1'b1, 10'b0110100110);
        word(10'b0110100110, 1'b1, 1'b1, 1'b0, 10'h000);
        word(cw(), 1'b0, 1'b1, 1'b0, 10'h000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Hard stop in case the initial block ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout cyc=%0d observed=running expected=finished", cyc);
        $fatal(1, "timeout");
    end

endmodule
